// File: rtl/tage_tag_gen.sv
// tage_tag_gen: keeps the global branch history and its two folded copies,
// and issues the registered lookup tag for one TAGE tagged table.
// The folds are updated incrementally, so the tag path never has to XOR
// the full history.
module tage_tag_gen #(
    parameter int HIST_LEN = 16,
    parameter int TAG_W    = 8,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lk_valid,
    input  logic [PC_W-1:0]     lk_pc,
    input  logic                upd_valid,
    input  logic                upd_taken,
    input  logic                ckpt_save,
    input  logic                ckpt_restore,
    output logic                tag_valid,
    output logic [TAG_W-1:0]    tag_out,
    output logic [HIST_LEN-1:0] ghr_out
);

    localparam int CSR2_W = TAG_W - 1;
    localparam int POS1   = HIST_LEN % TAG_W;
    localparam int POS2   = HIST_LEN % CSR2_W;

    logic [HIST_LEN-1:0] r_ghr;
    logic [TAG_W-1:0]    r_csr1;
    logic [CSR2_W-1:0]   r_csr2;
    logic [HIST_LEN-1:0] r_snapGhr;
    logic [TAG_W-1:0]    r_snapCsr1;
    logic [CSR2_W-1:0]   r_snapCsr2;
    logic                r_tagValid;
    logic [TAG_W-1:0]    r_tagOut;

    logic [HIST_LEN-1:0] w_ghrShift;
    logic [TAG_W-1:0]    w_csr1Shift;
    logic [CSR2_W-1:0]   w_csr2Shift;
    logic [TAG_W-1:0]    w_lookupTag;
    logic                w_unusedPc;

    // Only the low TAG_W bits of the PC feed the tag; the rest is sunk here.
    assign w_unusedPc = ^{1'b0, lk_pc};

    // History after shifting in the resolved outcome; the oldest bit falls off the top.
    always_comb begin
        w_ghrShift = {r_ghr[HIST_LEN-2:0], upd_taken};
    end

    // Folded histories after one update: rotate, fold the new bit in at 0 and
    // cancel the dropped bit where its chunk position would have landed.
    always_comb begin
        w_csr1Shift          = (r_csr1 << 1) | (r_csr1 >> (TAG_W - 1));
        w_csr1Shift[0]       = w_csr1Shift[0] ^ upd_taken;
        w_csr1Shift[POS1]    = w_csr1Shift[POS1] ^ r_ghr[HIST_LEN-1];
        w_csr2Shift          = (r_csr2 << 1) | (r_csr2 >> (CSR2_W - 1));
        w_csr2Shift[0]       = w_csr2Shift[0] ^ upd_taken;
        w_csr2Shift[POS2]    = w_csr2Shift[POS2] ^ r_ghr[HIST_LEN-1];
    end

    // Tag from the current (pre-update, pre-restore) folds.
    always_comb begin
        w_lookupTag = lk_pc[TAG_W-1:0] ^ r_csr1 ^ {r_csr2, 1'b0};
    end

    // History and fold registers: restore beats update, update otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ghr  <= '0;
            r_csr1 <= '0;
            r_csr2 <= '0;
        end else if (ckpt_restore) begin
            r_ghr  <= r_snapGhr;
            r_csr1 <= r_snapCsr1;
            r_csr2 <= r_snapCsr2;
        end else if (upd_valid) begin
            r_ghr  <= w_ghrShift;
            r_csr1 <= w_csr1Shift;
            r_csr2 <= w_csr2Shift;
        end
    end

    // Snapshot captures the pre-update state; a restore in the same cycle leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snapGhr  <= '0;
            r_snapCsr1 <= '0;
            r_snapCsr2 <= '0;
        end else if (ckpt_save && !ckpt_restore) begin
            r_snapGhr  <= r_ghr;
            r_snapCsr1 <= r_csr1;
            r_snapCsr2 <= r_csr2;
        end
    end

    // Registered tag output: one-cycle latency, tag holds when no lookup arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tagValid <= 1'b0;
            r_tagOut   <= '0;
        end else begin
            r_tagValid <= lk_valid;
            if (lk_valid) begin
                r_tagOut <= w_lookupTag;
            end
        end
    end

    assign tag_valid = r_tagValid;
    assign tag_out   = r_tagOut;
    assign ghr_out   = r_ghr;

endmodule

// File: tb/tb_tage_tag_gen.sv
// tb_tage_tag_gen: table vectors, hand-written corner sequences and random
// traffic against a reference that folds the whole history from scratch.
module tb_tage_tag_gen;

    localparam int HIST_LEN = 16;
    localparam int TAG_W    = 8;
    localparam int PC_W     = 32;

    typedef struct {
        logic                rst;
        logic                lkValid;
        logic [PC_W-1:0]     lkPc;
        logic                updValid;
        logic                updTaken;
        logic                save;
        logic                restore;
        logic                expTagValid;
        logic [TAG_W-1:0]    expTag;
        logic [HIST_LEN-1:0] expGhr;
    } vector_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                lk_valid;
    logic [PC_W-1:0]     lk_pc;
    logic                upd_valid;
    logic                upd_taken;
    logic                ckpt_save;
    logic                ckpt_restore;
    logic                tag_valid;
    logic [TAG_W-1:0]    tag_out;
    logic [HIST_LEN-1:0] ghr_out;

    logic [HIST_LEN-1:0] mGhr;
    logic [HIST_LEN-1:0] mSnap;
    logic                mTagValid;
    logic [TAG_W-1:0]    mTagOut;

    int checks = 0;
    int errors = 0;
    vector_t vecs[$];

    always #5 clk = ~clk;

    tage_tag_gen #(.HIST_LEN(HIST_LEN), .TAG_W(TAG_W), .PC_W(PC_W)) dut (
        .clk(clk),
        .reset(reset),
        .lk_valid(lk_valid),
        .lk_pc(lk_pc),
        .upd_valid(upd_valid),
        .upd_taken(upd_taken),
        .ckpt_save(ckpt_save),
        .ckpt_restore(ckpt_restore),
        .tag_valid(tag_valid),
        .tag_out(tag_out),
        .ghr_out(ghr_out)
    );

    // XOR of all w-wide chunks of the history.
    function automatic logic [TAG_W-1:0] fold(input logic [HIST_LEN-1:0] g, input int w);
        logic [TAG_W-1:0] f;
        f = '0;
        for (int i = 0; i < HIST_LEN; i++) begin
            f[i % w] = f[i % w] ^ g[i];
        end
        return f;
    endfunction

    // Reference reaction to one clock edge given the inputs currently driven.
    task automatic modelEdge();
        if (!reset) begin
            mGhr = '0; mSnap = '0; mTagValid = 1'b0; mTagOut = '0;
        end else begin
            mTagValid = lk_valid;
            if (lk_valid)
                mTagOut = lk_pc[TAG_W-1:0] ^ fold(mGhr, TAG_W) ^ (fold(mGhr, TAG_W - 1) << 1);
            if (ckpt_restore) begin
                mGhr = mSnap;
            end else begin
                if (ckpt_save) mSnap = mGhr;
                if (upd_valid) mGhr = {mGhr[HIST_LEN-2:0], upd_taken};
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic lkv, input logic [PC_W-1:0] pc,
                                 input logic uv, input logic ut, input logic sv, input logic rs);
        reset = rst; lk_valid = lkv; lk_pc = pc; upd_valid = uv; upd_taken = ut;
        ckpt_save = sv; ckpt_restore = rs;
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, ".tag_valid"}, 64'(tag_valid), 64'(mTagValid));
        checkVal({name, ".tag_out"},   64'(tag_out),   64'(mTagOut));
        checkVal({name, ".ghr"},       64'(ghr_out),   64'(mGhr));
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // rst lk pc uv ut save rest | tagValid tag ghr  (starts from reset state)
        vecs.push_back('{1, 1, 32'h0000_003C, 1, 1, 0, 0, 1, 8'h3C, 16'h0001});
        vecs.push_back('{1, 1, 32'h0000_0000, 0, 0, 0, 0, 1, 8'h03, 16'h0001});
        vecs.push_back('{1, 0, 32'h0000_0000, 1, 1, 1, 0, 0, 8'h03, 16'h0003});
        vecs.push_back('{1, 0, 32'h0000_0000, 1, 1, 0, 0, 0, 8'h03, 16'h0007});
        vecs.push_back('{1, 1, 32'h0000_0000, 1, 1, 0, 1, 1, 8'h09, 16'h0001});
        vecs.push_back('{1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 8'hFC, 16'h0001});
        vecs.push_back('{1, 1, 32'h1234_5600, 0, 0, 0, 1, 1, 8'h03, 16'h0001});

        reset = 1'b0; lk_valid = 1'b0; lk_pc = '0; upd_valid = 1'b0; upd_taken = 1'b0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        mGhr = '0; mSnap = '0; mTagValid = 1'b0; mTagOut = '0;

        // T1: reset held with inputs toggling, then first lookup
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b1, i[0]);
            checkVal("t1.tag_valid", 64'(tag_valid), 64'h0);
            checkVal("t1.tag_out",   64'(tag_out),   64'h0);
            checkVal("t1.ghr",       64'(ghr_out),   64'h0);
        end
        applyStimulus(1'b1, 1'b1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("t1.tag_a5", 64'(tag_out), 64'hA5);
        checkVal("t1.valid",  64'(tag_valid), 64'h1);

        // Table vectors (include T3 simultaneous lookup+update)
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].lkValid, vecs[i].lkPc, vecs[i].updValid,
                          vecs[i].updTaken, vecs[i].save, vecs[i].restore);
            checkVal($sformatf("vec%0d.tag_valid", i), 64'(tag_valid), 64'(vecs[i].expTagValid));
            checkVal($sformatf("vec%0d.tag_out", i),   64'(tag_out),   64'(vecs[i].expTag));
            checkVal($sformatf("vec%0d.ghr", i),       64'(ghr_out),   64'(vecs[i].expGhr));
        end

        // T2: sixteen taken updates fold to csr1=0x00, csr2=0x03
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("t2.ghr", 64'(ghr_out), 64'hFFFF);
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("t2.tag", 64'(tag_out), 64'h06);

        // T4: save after 3 taken, 5 not-taken, restore with update dropped
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("t4.ghr_pre", 64'(ghr_out), 64'h00E0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("t4.ghr_restored", 64'(ghr_out), 64'h0007);
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("t4.tag", 64'(tag_out), 64'h09);

        // T6: lookup in a reset cycle is discarded; restore after reset reloads zeros
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("t6.tag_valid", 64'(tag_valid), 64'h0);
        checkVal("t6.ghr",       64'(ghr_out),   64'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("t6.restore_zero", 64'(ghr_out), 64'h0);

        // T5: random traffic against the full-fold reference
        doReset();
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0), $urandom_range(0, 1) == 1, $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
            checkOutput("t5");
        end
        idle();
        checkOutput("t5.final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
